// File: rtl/rb_ser_tx.sv
// Reads DEPTH words from a synchronous buffer, then serialises one frame per
// bit-lane: channel index, payload bits in the selected order, optional even parity.
module rb_ser_tx #(
  parameter int DW     = 8,
  parameter int DEPTH  = 17,
  parameter int AW     = 5,
  parameter int IW     = 3,
  parameter int PAR_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode_lsb,
  output logic          rb_rw,
  output logic [AW-1:0] rb_a,
  output logic [DW-1:0] rb_d,
  input  logic [DW-1:0] rb_q,
  output logic          sen,
  output logic          sd,
  output logic          busy,
  output logic          done
);

  localparam int FL = IW + DEPTH + PAR_EN;
  localparam int PW = $clog2(FL + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] POS_LAST  = PW'(FL - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH);
  localparam logic [CW-1:0] RD_A_LAST = CW'(DEPTH - 1);
  localparam logic [IW-1:0] CH_LAST   = IW'(DW - 1);

  typedef enum logic [1:0] {IDLE, READ, SEND, GAP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] words [DEPTH];
  logic [CW-1:0] rd_cnt;
  logic [IW-1:0] chan, chan_n;
  logic [PW-1:0] pos, pos_n;
  logic          acc, acc_n;
  logic          sd_n, sen_n, done_n, busy_n;
  logic          mode;
  logic          par;
  logic [IW-1:0] sh;
  logic [DW-1:0] w;
  int            qi, k;

  assign rb_rw = 1'b1;
  assign rb_d  = '0;

  // sd is launched one cycle ahead: pos is the index of the bit currently on sd,
  // and acc holds the parity of the bits already sent before it.
  always_comb begin
    state_n = state;
    chan_n  = chan;
    pos_n   = pos;
    acc_n   = acc;
    sd_n    = 1'b0;
    sen_n   = 1'b1;
    done_n  = 1'b0;
    busy_n  = busy;
    par     = acc ^ sd;
    sh      = '0;
    w       = '0;
    qi      = int'(pos) + 1;
    k       = 0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          busy_n  = 1'b1;
          chan_n  = '0;
        end
      end
      READ: begin
        if (rd_cnt == RD_LAST) begin
          state_n = SEND;
          sen_n   = 1'b0;
          sd_n    = chan[IW-1];
          pos_n   = '0;
          acc_n   = 1'b0;
        end
      end
      SEND: begin
        if (pos == POS_LAST) begin
          if (chan == CH_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = GAP;
            chan_n  = chan + IW'(1);
          end
        end else begin
          sen_n = 1'b0;
          pos_n = pos + PW'(1);
          acc_n = par;
          if (qi < IW) begin
            sh   = chan >> (IW - 1 - qi);
            sd_n = sh[0];
          end else if (qi < IW + DEPTH) begin
            k    = mode ? (qi - IW) : (DEPTH - 1 - (qi - IW));
            w    = words[KW'(k)] >> (DW - 1 - int'(chan));
            sd_n = w[0];
          end else begin
            sd_n = par;
          end
        end
      end
      GAP: begin
        state_n = SEND;
        sen_n   = 1'b0;
        sd_n    = chan[IW-1];
        pos_n   = '0;
        acc_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      chan   <= '0;
      pos    <= '0;
      acc    <= 1'b0;
      sd     <= 1'b0;
      sen    <= 1'b1;
      done   <= 1'b0;
      busy   <= 1'b0;
      rb_a   <= '0;
      rd_cnt <= '0;
      mode   <= 1'b0;
    end else begin
      state <= state_n;
      chan  <= chan_n;
      pos   <= pos_n;
      acc   <= acc_n;
      sd    <= sd_n;
      sen   <= sen_n;
      done  <= done_n;
      busy  <= busy_n;
      if (state == IDLE && start) begin
        rd_cnt <= '0;
        rb_a   <= '0;
        mode   <= mode_lsb;
      end else if (state == READ) begin
        if (rd_cnt != RD_LAST) rd_cnt <= rd_cnt + CW'(1);
        if (rd_cnt < RD_A_LAST) rb_a <= rb_a + AW'(1);
      end
    end
  end

  // Read data lags its address by one cycle, so word rd_cnt-1 arrives now.
  always_ff @(posedge clk) begin
    if (state == READ && rd_cnt != '0) words[KW'(rd_cnt - CW'(1))] <= rb_q;
  end

endmodule

// File: tb/tb_rb_ser_tx.sv
// Scoreboard bench for rb_ser_tx: default-parameter instance plus a small
// DW=4 / DEPTH=8 / no-parity instance sharing clock and reset.
module tb_rb_ser_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, mode_a, start_b, mode_b;
  logic       rb_rw_a, sen_a, sd_a, busy_a, done_a;
  logic [4:0] rb_a_a;
  logic [7:0] rb_d_a, rb_q_a;
  logic       rb_rw_b, sen_b, sd_b, busy_b, done_b;
  logic [2:0] rb_a_b;
  logic [3:0] rb_d_b, rb_q_b;
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];

  rb_ser_tx dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode_lsb(mode_a),
    .rb_rw(rb_rw_a), .rb_a(rb_a_a), .rb_d(rb_d_a), .rb_q(rb_q_a),
    .sen(sen_a), .sd(sd_a), .busy(busy_a), .done(done_a)
  );

  rb_ser_tx #(.DW(4), .DEPTH(8), .AW(3), .IW(2), .PAR_EN(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode_lsb(mode_b),
    .rb_rw(rb_rw_b), .rb_a(rb_a_b), .rb_d(rb_d_b), .rb_q(rb_q_b),
    .sen(sen_b), .sd(sd_b), .busy(busy_b), .done(done_b)
  );

  always @(posedge clk) begin
    rb_q_a <= mem_a[rb_a_a];
    rb_q_b <= mem_b[rb_a_b][3:0];
  end

  typedef struct {
    int          len;
    logic [31:0] bits;
  } frame_t;

  frame_t qa[$];
  frame_t qb[$];
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_frame(input int c, input logic m, input int dw,
                                              input int depth, input int iw, input int par_en,
                                              input logic [7:0] mm [32]);
    logic [31:0] f;
    logic        p, b;
    int          kk;
    f = '0;
    p = 1'b0;
    for (int i = iw - 1; i >= 0; i--) begin
      b = ((c >> i) & 1) != 0;
      f = {f[30:0], b};
      p ^= b;
    end
    for (int j = 0; j < depth; j++) begin
      kk = m ? j : depth - 1 - j;
      b  = mm[kk][dw-1-c];
      f  = {f[30:0], b};
      p ^= b;
    end
    if (par_en != 0) f = {f[30:0], p};
    return f;
  endfunction

  task automatic push_a(input logic m);
    frame_t fr;
    for (int c = 0; c < 8; c++) begin
      fr.len  = 21;
      fr.bits = model_frame(c, m, 8, 17, 3, 1, mem_a);
      qa.push_back(fr);
    end
  endtask

  task automatic set_hand(input int c, input logic [31:0] bits);
    frame_t fr;
    fr      = qa[c];
    fr.bits = bits;
    qa[c]   = fr;
  endtask

  // Monitor A: collects frames while sen is low, checks gap length and idle sd.
  int          len_a = 0, gap_a = 0, fr_a = 0;
  logic [31:0] sh_a = '0;
  always @(negedge clk) begin
    frame_t e;
    if (rst) begin
      len_a = 0; sh_a = '0; gap_a = 0; fr_a = 0;
    end else begin
      if (!sen_a) begin
        if (len_a == 0 && fr_a > 0) check("gap_len_a", gap_a, 1);
        len_a++;
        sh_a = {sh_a[30:0], sd_a};
      end else begin
        if (sd_a !== 1'b0) check("sd_idle_a", sd_a, 0);
        if (len_a > 0) begin
          if (qa.size() == 0) begin
            check("frame_unexpected_a", 1, 0);
          end else begin
            e = qa.pop_front();
            check($sformatf("frame_len_a#%0d", fr_a), len_a, e.len);
            check($sformatf("frame_bits_a#%0d", fr_a), sh_a, e.bits);
          end
          len_a = 0; sh_a = '0; gap_a = 1; fr_a++;
        end else if (busy_a) begin
          gap_a++;
        end
        if (!busy_a) fr_a = 0;
      end
      if (done_a) done_cnt_a++;
    end
  end

  int          len_b = 0, fr_b = 0;
  logic [31:0] sh_b = '0;
  always @(negedge clk) begin
    frame_t e;
    if (rst) begin
      len_b = 0; sh_b = '0;
    end else begin
      if (!sen_b) begin
        len_b++;
        sh_b = {sh_b[30:0], sd_b};
      end else if (len_b > 0) begin
        if (qb.size() == 0) begin
          check("frame_unexpected_b", 1, 0);
        end else begin
          e = qb.pop_front();
          check($sformatf("frame_len_b#%0d", fr_b), len_b, e.len);
          check($sformatf("frame_bits_b#%0d", fr_b), sh_b, e.bits);
        end
        len_b = 0; sh_b = '0; fr_b++;
      end
      if (done_b) done_cnt_b++;
    end
  end

  // Called on a negedge; returns the negedge count from start sample to done.
  task automatic run_a(input logic m, input int poke, input int abort_at, output int ncyc);
    start_a = 1'b1;
    mode_a  = m;
    ncyc    = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) start_a = 1'b0;
      if (poke > 0 && ncyc == poke) begin
        start_a = 1'b1;
        mode_a  = ~m;
      end
      if (poke > 0 && ncyc == poke + 1) start_a = 1'b0;
      if (ncyc == abort_at || done_a) break;
    end
  endtask

  task automatic full_a(input string name, input logic m, input int poke);
    int ncyc, d0;
    d0 = done_cnt_a;
    run_a(m, poke, 0, ncyc);
    check({name, "_done_cycle"}, ncyc, 194);
    @(negedge clk);
    check({name, "_done_count"}, done_cnt_a - d0, 1);
    check({name, "_queue_empty"}, qa.size(), 0);
    check({name, "_busy_low"}, busy_a, 0);
    check({name, "_rb_a_hold"}, rb_a_a, 16);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ncyc, d0;
    rst = 1'b1; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'(i & 7);
    end
    repeat (3) @(negedge clk);
    check("rst_rb_rw", rb_rw_a, 1);
    check("rst_sen", sen_a, 1);
    check("rst_rb_a", rb_a_a, 0);
    check("rst_rb_d", rb_d_a, 0);
    check("rst_sd", sd_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // all-zero buffer; ch5 = 101, 17 zeros, parity 0
    push_a(1'b0);
    set_hand(5, 32'h140000);
    full_a("zeros", 1'b0, 0);

    // all-ones buffer; ch0 = 000 + 18 ones, ch3 = 011 + 18 ones
    for (int i = 0; i < 32; i++) mem_a[i] = 8'hFF;
    push_a(1'b0);
    set_hand(0, 32'h03FFFF);
    set_hand(3, 32'h0FFFFF);
    full_a("ones", 1'b0, 0);

    for (int i = 0; i < 32; i++) mem_a[i] = 8'h00;
    mem_a[0] = 8'h80;
    push_a(1'b0);
    set_hand(0, 32'h000003);
    full_a("w0_msb_first", 1'b0, 0);
    push_a(1'b1);
    set_hand(0, 32'h020001);
    full_a("w0_lsb_first", 1'b1, 0);

    // restart attempt and mode flip in the middle of SEND
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(i * 37 + 5);
    push_a(1'b0);
    full_a("ignore_start", 1'b0, 100);

    // abort inside the ch4 frame, then a clean transfer
    push_a(1'b1);
    d0 = done_cnt_a;
    run_a(1'b1, 0, 110, ncyc);
    check("abort_mid_frame", sen_a, 0);
    #2 rst = 1'b1;
    #1;
    check("abort_sen", sen_a, 1);
    check("abort_sd", sd_a, 0);
    check("abort_busy", busy_a, 0);
    qa.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", done_cnt_a - d0, 0);
    push_a(1'b1);
    full_a("after_abort", 1'b1, 0);

    // narrow instance: 4 frames of 10 bits, no parity
    for (int c = 0; c < 4; c++) begin
      frame_t fr;
      fr.len  = 10;
      fr.bits = model_frame(c, 1'b0, 4, 8, 2, 0, mem_b);
      qb.push_back(fr);
    end
    d0 = done_cnt_b;
    start_b = 1'b1;
    mode_b  = 1'b0;
    ncyc    = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ncyc++;
      start_b = 1'b0;
      if (done_b) break;
    end
    check("b_done_cycle", ncyc, 53);
    @(negedge clk);
    check("b_done_count", done_cnt_b - d0, 1);
    check("b_queue_empty", qb.size(), 0);
    check("b_rb_a_hold", rb_a_b, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
